// File: rtl/cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cmp_share_arbiter
// Brief    : One shared 32-bit compare unit (A-B) arbitrated among NUM_REQ
//            requesters; fixed 3-cycle transaction ending in a one-hot done.
//            Define CMP_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  operand_a_flat,
    input  logic [32*NUM_REQ-1:0]  operand_b_flat,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   isEqual,
    output logic                   isLessThan,
    output logic                   isGreaterThan,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATCH   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [31:0]        op_a_q, op_a_d;
    logic [31:0]        op_b_q, op_b_d;
    logic [31:0]        diff;
    logic               eq_q, eq_d;
    logic               lt_q, lt_d;
    logic               gt_q, gt_d;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;

`ifdef CMP_ARB_FIXED_PRIO_EN
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[k]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]      cand;

    // Search begins just past the previous winner and wraps modulo NUM_REQ.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(rr_ptr_q) + 32'(k);
            if (cand >= 32'(NUM_REQ)) begin
                cand = cand - 32'(NUM_REQ);
            end
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end
`endif

    // Wrapped difference; the sign bit alone defines less-than (no overflow fix).
    assign diff = op_a_q + ~op_b_q + 32'd1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
`ifndef CMP_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    op_a_d  = operand_a_flat[{win_idx, 5'b0} +: 32];
                    op_b_d  = operand_b_flat[{win_idx, 5'b0} +: 32];
`ifndef CMP_ARB_FIXED_PRIO_EN
                    rr_ptr_d = win_idx;
`endif
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                eq_d    = (diff == 32'd0);
                lt_d    = diff[31];
                gt_d    = (diff != 32'd0) & ~diff[31];
                state_d = ST_DONE;
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
`ifndef CMP_ARB_FIXED_PRIO_EN
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
`ifndef CMP_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign grant         = grant_q;
    assign done          = (state_q == ST_DONE) ? grant_q : '0;
    assign busy          = (state_q != ST_IDLE);
    assign isEqual       = eq_q;
    assign isLessThan    = lt_q;
    assign isGreaterThan = gt_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_share_arbiter
// Brief    : Directed scoreboard bench for cmp_share_arbiter (NUM_REQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_share_arbiter;

    localparam int NUM_REQ = 4;

    typedef struct packed {
        logic [NUM_REQ-1:0] d;
        logic               eq;
        logic               lt;
        logic               gt;
    } exp_t;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req = '0;
    logic [32*NUM_REQ-1:0] a_flat = '0;
    logic [32*NUM_REQ-1:0] b_flat = '0;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    done;
    logic                  isEqual, isLessThan, isGreaterThan, busy;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    cmp_share_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .operand_a_flat (a_flat),
        .operand_b_flat (b_flat),
        .grant          (grant),
        .done           (done),
        .isEqual        (isEqual),
        .isLessThan     (isLessThan),
        .isGreaterThan  (isGreaterThan),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, expv, $time);
        end
    endtask

    task automatic push(input int idx, input logic eq, input logic lt, input logic gt);
        exp_t e;
        e.d  = NUM_REQ'(1) << idx;
        e.eq = eq;
        e.lt = lt;
        e.gt = gt;
        exp_q.push_back(e);
    endtask

    // One full transaction; returns in IDLE with req released.
    task automatic do_cmp(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic eq, input logic lt, input logic gt);
        req               = NUM_REQ'(1) << idx;
        a_flat[32*idx+:32] = a;
        b_flat[32*idx+:32] = b;
        push(idx, eq, lt, gt);
        tick();
        chk("grant", 32'(grant), 32'(NUM_REQ'(1) << idx));
        chk("busy_hi", 32'(busy), 32'd1);
        tick();
        tick();
        chk("done_cyc3", 32'(done), 32'(NUM_REQ'(1) << idx));
        tick();
        req = '0;
        chk("busy_lo", 32'(busy), 32'd0);
        chk("grant_lo", 32'(grant), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done !== '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done got=%b at %0t", done, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({done, isEqual, isLessThan, isGreaterThan} !== e) begin
                    bad++;
                    $display("FAIL result got done=%b eq=%b lt=%b gt=%b exp done=%b eq=%b lt=%b gt=%b",
                             done, isEqual, isLessThan, isGreaterThan, e.d, e.eq, e.lt, e.gt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({isEqual, isLessThan, isGreaterThan}), 32'd0);

        // Basic compares, including wrapped-sign behaviour
        do_cmp(0, 32'd5, 32'd9, 1'b0, 1'b1, 1'b0);
        do_cmp(1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        do_cmp(1, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
        do_cmp(3, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        do_cmp(0, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b1);

        // Operand change after capture is ignored
        req            = 4'b0100;
        a_flat[64+:32] = 32'd3;
        b_flat[64+:32] = 32'd10;
        push(2, 1'b0, 1'b1, 1'b0);
        tick();
        chk("opchg_grant", 32'(grant), 32'h4);
        tick();
        a_flat[64+:32] = 32'd50;
        tick();
        tick();
        req = '0;

        // Round-robin from reset: requester 0 first, then 1, 2, 3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_flat[32*i+:32] = 32'(i * 10);
            b_flat[32*i+:32] = 32'd20;
        end
        push(0, 1'b0, 1'b1, 1'b0);
        push(1, 1'b0, 1'b1, 1'b0);
        push(2, 1'b1, 1'b0, 1'b0);
        push(3, 1'b0, 1'b0, 1'b1);
        req = 4'b1111;
        for (int k = 0; k < NUM_REQ; k++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(NUM_REQ'(1) << k));
            tick();
            tick();
            tick();
            req[k] = 1'b0;
        end

        // Reset during COMPARE: no done, flags cleared, pending req served after
        req            = 4'b0010;
        a_flat[32+:32] = 32'd1;
        b_flat[32+:32] = 32'd2;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_flags", 32'({isEqual, isLessThan, isGreaterThan}), 32'd0);
        push(1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("post_rst_grant", 32'(grant), 32'h2);
        tick();
        tick();
        chk("post_rst_done", 32'(done), 32'h2);
        tick();
        req = '0;
        tick();
        tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
